// File: rtl/insight_commit_trace_packer_if.sv
// Commit-lane input and single-record trace output bundle for the commit trace packer.
interface insight_commit_trace_packer_if #(
  parameter int ADDR_W = 40,
  parameter int INSN_W = 32
);
  logic              in0_valid;
  logic [ADDR_W-1:0] in0_iaddr;
  logic [INSN_W-1:0] in0_insn;
  logic              in0_exc;
  logic              in1_valid;
  logic [ADDR_W-1:0] in1_iaddr;
  logic [INSN_W-1:0] in1_insn;
  logic              in1_exc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_iaddr;
  logic [INSN_W-1:0] out_insn;
  logic              out_exc;
  logic              out_lost;

  modport master (
    output in0_valid, in0_iaddr, in0_insn, in0_exc,
    output in1_valid, in1_iaddr, in1_insn, in1_exc,
    output out_ready,
    input  out_valid, out_iaddr, out_insn, out_exc, out_lost
  );

  modport slave (
    input  in0_valid, in0_iaddr, in0_insn, in0_exc,
    input  in1_valid, in1_iaddr, in1_insn, in1_exc,
    input  out_ready,
    output out_valid, out_iaddr, out_insn, out_exc, out_lost
  );
endinterface

// File: rtl/insight_commit_trace_packer.sv
// Packs 0-2 commit records per cycle into a FIFO drained as one record per handshake;
// overflow drops records, counts them and flags the next surviving record as lost.
module insight_commit_trace_packer #(
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 40,
  parameter  int INSN_W = 32,
  parameter  int DROP_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  insight_commit_trace_packer_if.slave tr,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [DROP_W-1:0]     drop_count,
  output logic [63:0]           retire_count,
  output logic                  overflow_stky
);

  typedef struct packed {
    logic [ADDR_W-1:0] iaddr;
    logic [INSN_W-1:0] insn;
    logic              exc;
    logic              lost;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             pending_lost;

  logic             k0, k1, deq;
  logic [1:0]       kin, kept, dropped;
  logic [LVL_W-1:0] free, level_nxt;
  logic [DROP_W:0]  drop_sum;
  rec_t             rec_a, rec_b;

  always_comb begin
    k0    = enable & tr.in0_valid;
    k1    = enable & tr.in1_valid;
    kin   = {1'b0, k0} + {1'b0, k1};
    // Free space comes from the registered level only; a same-cycle pop is not credited.
    free  = LVL_W'(DEPTH) - fifo_level;
    kept  = (free >= LVL_W'(kin)) ? kin : free[1:0];
    dropped = kin - kept;
    deq   = (fifo_level != '0) & tr.out_ready;
    level_nxt = fifo_level + LVL_W'(kept) - LVL_W'(deq);
    drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(dropped);
    // Oldest record first: lane 0 if present, else a lone lane 1.
    rec_a.iaddr = k0 ? tr.in0_iaddr : tr.in1_iaddr;
    rec_a.insn  = k0 ? tr.in0_insn  : tr.in1_insn;
    rec_a.exc   = k0 ? tr.in0_exc   : tr.in1_exc;
    rec_a.lost  = pending_lost;
    rec_b.iaddr = tr.in1_iaddr;
    rec_b.insn  = tr.in1_insn;
    rec_b.exc   = tr.in1_exc;
    rec_b.lost  = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr          <= '0;
      rptr          <= '0;
      fifo_level    <= '0;
      pending_lost  <= 1'b0;
      drop_count    <= '0;
      retire_count  <= '0;
      overflow_stky <= 1'b0;
    end else begin
      if (kept != 2'd0) mem[wptr] <= rec_a;
      if (kept == 2'd2) mem[wptr + PTR_W'(1)] <= rec_b;
      wptr       <= wptr + PTR_W'(kept);
      rptr       <= rptr + PTR_W'(deq);
      fifo_level <= level_nxt;
      // A drop always leaves the flag set for the next survivor, even if lane 0 was kept.
      if (dropped != 2'd0)   pending_lost <= 1'b1;
      else if (kept != 2'd0) pending_lost <= 1'b0;
      if (clear) begin
        drop_count    <= '0;
        retire_count  <= '0;
        overflow_stky <= 1'b0;
      end else begin
        drop_count    <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        retire_count  <= retire_count + 64'(kin);
        if (dropped != 2'd0) overflow_stky <= 1'b1;
      end
    end
  end

  assign tr.out_valid = (fifo_level != '0);
  assign tr.out_iaddr = mem[rptr].iaddr;
  assign tr.out_insn  = mem[rptr].insn;
  assign tr.out_exc   = mem[rptr].exc;
  assign tr.out_lost  = mem[rptr].lost;

endmodule

// File: tb/tb_insight_commit_trace_packer.sv
// Scoreboard bench: stimulus pushes expected records; a negedge monitor checks the output stream.
module tb_insight_commit_trace_packer;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;
  logic [63:0] retire_count;
  logic        overflow_stky;

  insight_commit_trace_packer_if #(.ADDR_W(40), .INSN_W(32)) tr ();

  insight_commit_trace_packer #(.DEPTH(DEPTH), .ADDR_W(40), .INSN_W(32), .DROP_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .tr(tr),
    .fifo_level(fifo_level), .drop_count(drop_count),
    .retire_count(retire_count), .overflow_stky(overflow_stky)
  );

  always #5 clock = ~clock;

  typedef struct { bit v; logic [39:0] a; logic [31:0] i; bit e; } lane_t;
  typedef struct { logic [39:0] a; logic [31:0] i; bit e; bit lost; } rec_t;

  rec_t        exp_q[$];
  int          vecs = 0;
  int          errs = 0;
  int          mlevel = 0;
  int          mdrop = 0;
  bit          mpend = 0;
  bit          mstky = 0;
  logic [63:0] mret = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic lane_t mk(input logic [39:0] a);
    lane_t l;
    l.v = 1'b1; l.a = a; l.i = $urandom(); l.e = $urandom_range(0, 1) == 1;
    return l;
  endfunction

  function automatic lane_t none();
    lane_t l;
    l.v = 1'b0; l.a = '0; l.i = '0; l.e = 1'b0;
    return l;
  endfunction

  function automatic logic [39:0] raddr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  // Reference: records in program order either fit in the space left at the last edge or are dropped.
  task automatic model(input lane_t l0, input lane_t l1, input bit en, input bit rdy, input bit clr);
    lane_t recs[$];
    int    freev, kept, dropped;
    bit    deq;
    rec_t  r;
    deq = (mlevel > 0) && rdy;
    freev = DEPTH - mlevel;
    kept = 0; dropped = 0;
    if (en && l0.v) recs.push_back(l0);
    if (en && l1.v) recs.push_back(l1);
    foreach (recs[j]) begin
      if (freev > 0) begin
        r.a = recs[j].a; r.i = recs[j].i; r.e = recs[j].e; r.lost = mpend;
        mpend = 0;
        exp_q.push_back(r);
        freev--; kept++;
      end else begin
        dropped++;
        mpend = 1;
      end
    end
    if (clr) begin
      mdrop = 0; mret = '0; mstky = 0;
    end else begin
      mdrop = (mdrop + dropped > 65535) ? 65535 : mdrop + dropped;
      mret  = mret + 64'(recs.size());
      if (dropped > 0) mstky = 1;
    end
    mlevel = mlevel + kept - (deq ? 1 : 0);
  endtask

  task automatic step(input lane_t l0, input lane_t l1, input bit en, input bit rdy, input bit clr);
    tr.in0_valid = l0.v; tr.in0_iaddr = l0.a; tr.in0_insn = l0.i; tr.in0_exc = l0.e;
    tr.in1_valid = l1.v; tr.in1_iaddr = l1.a; tr.in1_insn = l1.i; tr.in1_exc = l1.e;
    tr.out_ready = rdy; enable = en; clear = clr;
    @(posedge clock);
    model(l0, l1, en, rdy, clr);
    #1;
    chk("fifo_level", 64'(fifo_level), 64'(mlevel));
    chk("drop_count", 64'(drop_count), 64'(mdrop));
    chk("retire_count", retire_count, mret);
    chk("overflow_stky", 64'(overflow_stky), 64'(mstky));
  endtask

  task automatic chk_reset_outputs();
    chk("reset_out_valid", 64'(tr.out_valid), 64'd0);
    chk("reset_out_iaddr", 64'(tr.out_iaddr), 64'd0);
    chk("reset_out_insn_exc_lost", {30'd0, tr.out_insn, tr.out_exc, tr.out_lost}, 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_counters", {47'd0, drop_count, overflow_stky}, 64'd0);
    chk("reset_retire", retire_count, 64'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 chk_reset_outputs();
    exp_q.delete();
    mlevel = 0; mdrop = 0; mpend = 0; mstky = 0; mret = '0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int c = 0; c < n; c++) step(none(), none(), 1'b1, rdy, 1'b0);
  endtask

  // Monitor: mid-cycle, compare head against the oldest expected record; pop on handshake.
  always @(negedge clock) begin
    if (reset) begin
      chk("out_valid", 64'(tr.out_valid), 64'(exp_q.size() != 0));
      if (tr.out_valid && exp_q.size() != 0) begin
        vecs++;
        if ({tr.out_iaddr, tr.out_insn, tr.out_exc, tr.out_lost} !==
            {exp_q[0].a, exp_q[0].i, exp_q[0].e, exp_q[0].lost}) begin
          errs++;
          $display("FAIL head_record: got a=%0h i=%0h e=%0b lost=%0b expected a=%0h i=%0h e=%0b lost=%0b",
                   tr.out_iaddr, tr.out_insn, tr.out_exc, tr.out_lost,
                   exp_q[0].a, exp_q[0].i, exp_q[0].e, exp_q[0].lost);
        end
        if (tr.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    tr.in0_valid = 0; tr.in0_iaddr = '0; tr.in0_insn = '0; tr.in0_exc = 0;
    tr.in1_valid = 0; tr.in1_iaddr = '0; tr.in1_insn = '0; tr.in1_exc = 0;
    tr.out_ready = 0;
    repeat (2) @(posedge clock);
    #1 chk_reset_outputs();
    reset = 1'b1;

    // Single lane, then empty.
    step(mk(40'h00_8000_0000), none(), 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Dual-lane order.
    step(mk(40'h100), mk(40'h104), 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Lone lane 1 is a single record.
    step(none(), mk(40'h180), 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Overflow: five dual cycles into an 8-deep FIFO with no drain.
    do_reset();
    for (int c = 0; c < 5; c++) step(mk(raddr()), mk(raddr()), 1'b1, 1'b0, 1'b0);
    chk("ovf_level_full", 64'(fifo_level), 64'd8);
    chk("ovf_drop2", 64'(drop_count), 64'd2);
    step(none(), none(), 1'b1, 1'b1, 1'b0);
    step(mk(40'h900), none(), 1'b1, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Partial fit at level 7.
    do_reset();
    for (int c = 0; c < 3; c++) step(mk(raddr()), mk(raddr()), 1'b1, 1'b0, 1'b0);
    step(mk(raddr()), none(), 1'b1, 1'b0, 1'b0);
    step(mk(40'h200), mk(40'h204), 1'b1, 1'b0, 1'b0);
    chk("partial_drop1", 64'(drop_count), 64'd1);
    step(none(), none(), 1'b1, 1'b1, 1'b0);
    step(mk(40'h300), none(), 1'b1, 1'b1, 1'b0);
    idle(10, 1'b1);

    // enable=0 ignores lanes entirely.
    step(mk(40'h400), mk(40'h404), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Backpressure toggling over 20 records.
    for (int c = 0; c < 20; c++) step(mk(raddr()), none(), 1'b1, c[0], 1'b0);
    idle(40, 1'b0 + 1'b1);

    // Clear with a same-cycle drop.
    for (int c = 0; c < 4; c++) step(mk(raddr()), mk(raddr()), 1'b1, 1'b0, 1'b0);
    step(mk(raddr()), mk(raddr()), 1'b1, 1'b0, 1'b1);
    chk("clear_drop_zero", 64'(drop_count), 64'd0);
    step(none(), none(), 1'b1, 1'b1, 1'b0);
    step(mk(40'h500), none(), 1'b1, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Reset in the middle of a stream.
    for (int c = 0; c < 3; c++) step(mk(raddr()), mk(raddr()), 1'b1, 1'b0, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      lane_t l0, l1;
      l0 = ($urandom_range(0, 9) < 6) ? mk(raddr()) : none();
      l1 = ($urandom_range(0, 9) < 5) ? mk(raddr()) : none();
      step(l0, l1, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end
    idle(DEPTH + 2, 1'b1);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
